// File: rtl/pcie_rq_arbiter.sv
// pcie_rq_arbiter: packet-level 2:1 arbiter in front of the PCIe RQ stream.
// Port 0 carries user DMA requests, port 1 carries ATS invalidation
// completions. A granted port owns the stream until its tlast beat, and a
// 2-entry output buffer decouples the upstream ready from m_axis_tready.
module pcie_rq_arbiter #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int RQ_AXIS_TUSER_W = 183,
    parameter int PRIORITY_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXIS_DATA_WIDTH-1:0]   s0_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s0_axis_tkeep,
    input  logic [RQ_AXIS_TUSER_W-1:0]   s0_axis_tuser,
    input  logic                         s0_axis_tlast,
    input  logic                         s0_axis_tvalid,
    output logic                         s0_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s1_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s1_axis_tkeep,
    input  logic [RQ_AXIS_TUSER_W-1:0]   s1_axis_tuser,
    input  logic                         s1_axis_tlast,
    input  logic                         s1_axis_tvalid,
    output logic                         s1_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [RQ_AXIS_TUSER_W-1:0]   m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         grant_port,
    output logic                         busy,
    output logic [15:0]                  pkt_cnt0,
    output logic [15:0]                  pkt_cnt1
);
    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]                 state_reg;
    logic                       grant_reg;
    logic                       last_grant_reg;
    logic [15:0]                cnt0_reg;
    logic [15:0]                cnt1_reg;
    logic [1:0]                 count_reg;

    // Head entry drives m_axis directly; tail entry holds the second beat.
    logic [AXIS_DATA_WIDTH-1:0] head_data_reg, tail_data_reg;
    logic [KEEP_W-1:0]          head_keep_reg, tail_keep_reg;
    logic [RQ_AXIS_TUSER_W-1:0] head_user_reg, tail_user_reg;
    logic                       head_last_reg, tail_last_reg;

    logic [1:0]                 in_valid;
    logic [1:0]                 in_ready;
    logic                       busy_state;
    logic                       full;
    logic                       winner;
    logic [AXIS_DATA_WIDTH-1:0] sel_data;
    logic [KEEP_W-1:0]          sel_keep;
    logic [RQ_AXIS_TUSER_W-1:0] sel_user;
    logic                       sel_last;
    logic                       accept;
    logic                       pkt_done;
    logic                       pop;
    logic                       head_from_in;
    logic                       head_from_tail;
    logic                       tail_load;

    assign in_valid   = {s1_axis_tvalid, s0_axis_tvalid};
    assign busy_state = (state_reg == ST_BUSY);
    // Ready depends on the registered fill level only, so there is no
    // combinational path from m_axis_tready back to the requesters.
    assign full       = (count_reg == 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign in_ready[gi] = busy_state && !full && (grant_reg == 1'(gi));
        end
    endgenerate

    assign s0_axis_tready = in_ready[0];
    assign s1_axis_tready = in_ready[1];

    // Route the granted port's beat toward the buffer.
    always_comb begin
        sel_data = s0_axis_tdata;
        sel_keep = s0_axis_tkeep;
        sel_user = s0_axis_tuser;
        sel_last = s0_axis_tlast;
        if (grant_reg) begin
            sel_data = s1_axis_tdata;
            sel_keep = s1_axis_tkeep;
            sel_user = s1_axis_tuser;
            sel_last = s1_axis_tlast;
        end
    end

    assign accept   = |(in_valid & in_ready);
    assign pkt_done = accept && sel_last;
    assign pop      = (count_reg != 2'd0) && m_axis_tready;

    // Pick the next owner: fixed ATS priority, or alternate on contention.
    always_comb begin
        winner = in_valid[1];
        if (PRIORITY_MODE == 0 && in_valid == 2'b11) begin
            winner = ~last_grant_reg;
        end
    end

    // Grant FSM: hold the winner until its tlast beat is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|in_valid) begin
                        state_reg <= ST_BUSY;
                        grant_reg <= winner;
                    end
                end
                default: begin
                    if (pkt_done) begin
                        state_reg      <= ST_IDLE;
                        last_grant_reg <= grant_reg;
                    end
                end
            endcase
        end
    end

    // Per-port packet counters, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt0_reg <= 16'd0;
            cnt1_reg <= 16'd0;
        end else if (pkt_done) begin
            if (grant_reg) begin
                cnt1_reg <= cnt1_reg + 16'd1;
            end else begin
                cnt0_reg <= cnt0_reg + 16'd1;
            end
        end
    end

    // Buffer fill level; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The head takes the incoming beat when it would otherwise be empty,
    // or shifts up from the tail when the current head leaves.
    assign head_from_in   = accept && ((count_reg == 2'd0) || (pop && count_reg == 2'd1));
    assign head_from_tail = pop && (count_reg == 2'd2);
    assign tail_load      = accept && !pop && (count_reg == 2'd1);

    // Head entry registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_data_reg <= '0;
            head_keep_reg <= '0;
            head_user_reg <= '0;
            head_last_reg <= 1'b0;
        end else if (head_from_in) begin
            head_data_reg <= sel_data;
            head_keep_reg <= sel_keep;
            head_user_reg <= sel_user;
            head_last_reg <= sel_last;
        end else if (head_from_tail) begin
            head_data_reg <= tail_data_reg;
            head_keep_reg <= tail_keep_reg;
            head_user_reg <= tail_user_reg;
            head_last_reg <= tail_last_reg;
        end
    end

    // Tail entry registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tail_data_reg <= '0;
            tail_keep_reg <= '0;
            tail_user_reg <= '0;
            tail_last_reg <= 1'b0;
        end else if (tail_load) begin
            tail_data_reg <= sel_data;
            tail_keep_reg <= sel_keep;
            tail_user_reg <= sel_user;
            tail_last_reg <= sel_last;
        end
    end

    assign m_axis_tdata  = head_data_reg;
    assign m_axis_tkeep  = head_keep_reg;
    assign m_axis_tuser  = head_user_reg;
    assign m_axis_tlast  = head_last_reg;
    assign m_axis_tvalid = (count_reg != 2'd0);
    assign grant_port    = grant_reg;
    assign busy          = busy_state;
    assign pkt_cnt0      = cnt0_reg;
    assign pkt_cnt1      = cnt1_reg;

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Bench for pcie_rq_arbiter: two instances (round-robin and fixed ATS
// priority) driven from per-port beat queues; accepted beats feed an
// expected-output scoreboard that is checked as beats leave m_axis.
module tb_pcie_rq_arbiter;
    localparam int W  = 512;
    localparam int KW = W / 8;
    localparam int UW = 183;

    typedef struct packed {
        logic [31:0] tag;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic [W-1:0]  s_tdata  [2][2];
    logic [KW-1:0] s_tkeep  [2][2];
    logic [UW-1:0] s_tuser  [2][2];
    logic          s_tlast  [2][2];
    logic          s_tvalid [2][2];
    logic          s_tready [2][2];
    logic [W-1:0]  m_tdata  [2];
    logic [KW-1:0] m_tkeep  [2];
    logic [UW-1:0] m_tuser  [2];
    logic          m_tlast  [2];
    logic          m_tvalid [2];
    logic          m_tready [2];
    logic          grant    [2];
    logic          busy     [2];
    logic [15:0]   cnt0     [2];
    logic [15:0]   cnt1     [2];

    beat_t       src_q   [2][2][$];
    beat_t       exp_q   [2][$];
    int          out_pkts[2][$];
    int          out_cyc [2][$];
    logic [15:0] exp_cnt [2][2];
    logic        acc     [2][2];
    int          open_port[2];
    int          checks;
    int          passed;
    int          cyc;
    bit          flush_req;
    beat_t       mon_e;

    always #5 clk = ~clk;

    pcie_rq_arbiter #(.AXIS_DATA_WIDTH(W), .RQ_AXIS_TUSER_W(UW), .PRIORITY_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s_tdata[0][0]), .s0_axis_tkeep(s_tkeep[0][0]), .s0_axis_tuser(s_tuser[0][0]),
        .s0_axis_tlast(s_tlast[0][0]), .s0_axis_tvalid(s_tvalid[0][0]), .s0_axis_tready(s_tready[0][0]),
        .s1_axis_tdata(s_tdata[0][1]), .s1_axis_tkeep(s_tkeep[0][1]), .s1_axis_tuser(s_tuser[0][1]),
        .s1_axis_tlast(s_tlast[0][1]), .s1_axis_tvalid(s_tvalid[0][1]), .s1_axis_tready(s_tready[0][1]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tuser(m_tuser[0]),
        .m_axis_tlast(m_tlast[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .grant_port(grant[0]), .busy(busy[0]), .pkt_cnt0(cnt0[0]), .pkt_cnt1(cnt1[0])
    );

    pcie_rq_arbiter #(.AXIS_DATA_WIDTH(W), .RQ_AXIS_TUSER_W(UW), .PRIORITY_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s_tdata[1][0]), .s0_axis_tkeep(s_tkeep[1][0]), .s0_axis_tuser(s_tuser[1][0]),
        .s0_axis_tlast(s_tlast[1][0]), .s0_axis_tvalid(s_tvalid[1][0]), .s0_axis_tready(s_tready[1][0]),
        .s1_axis_tdata(s_tdata[1][1]), .s1_axis_tkeep(s_tkeep[1][1]), .s1_axis_tuser(s_tuser[1][1]),
        .s1_axis_tlast(s_tlast[1][1]), .s1_axis_tvalid(s_tvalid[1][1]), .s1_axis_tready(s_tready[1][1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tuser(m_tuser[1]),
        .m_axis_tlast(m_tlast[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .grant_port(grant[1]), .busy(busy[1]), .pkt_cnt0(cnt0[1]), .pkt_cnt1(cnt1[1])
    );

    function automatic logic [31:0] mk_tag(input int d, input int p, input int pid, input int b);
        return {8'(d), 8'(p), 8'(pid), 8'(b)};
    endfunction

    function automatic logic [W-1:0] mk_data(input logic [31:0] t);
        return {16{t}};
    endfunction

    function automatic logic [KW-1:0] mk_keep(input logic [31:0] t);
        return {2{t}};
    endfunction

    function automatic logic [UW-1:0] mk_user(input logic [31:0] t);
        logic [191:0] u;
        u = {6{~t}};
        return u[UW-1:0];
    endfunction

    task automatic queue_pkt(input int d, input int p, input int n, input int pid);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.tag  = mk_tag(d, p, pid, b);
            bt.last = (b == n - 1);
            src_q[d][p].push_back(bt);
        end
        exp_cnt[d][p] = exp_cnt[d][p] + 16'd1;
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            out_pkts[d].delete();
            out_cyc[d].delete();
        end
    endtask

    task automatic wait_drain(output bit ok);
        bit idle;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            idle = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (src_q[d][0].size() != 0 || src_q[d][1].size() != 0 || m_tvalid[d] || busy[d])
                    idle = 1'b0;
            end
            if (idle) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Source drivers, acceptance scoreboard push and output monitor.
    initial begin
        int nacc;
        int pa;
        for (int d = 0; d < 2; d++) begin
            open_port[d] = -1;
            for (int p = 0; p < 2; p++) begin
                s_tdata[d][p] = '0; s_tkeep[d][p] = '0; s_tuser[d][p] = '0;
                s_tlast[d][p] = 1'b0; s_tvalid[d][p] = 1'b0; acc[d][p] = 1'b0;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                nacc = 0;
                pa = 0;
                for (int p = 0; p < 2; p++) begin
                    acc[d][p] = s_tvalid[d][p] && s_tready[d][p];
                    if (acc[d][p] && src_q[d][p].size() > 0) begin
                        exp_q[d].push_back(src_q[d][p][0]);
                        nacc++;
                        pa = p;
                    end
                end
                if (nacc > 0) begin
                    checks++;
                    if (nacc > 1 || (open_port[d] >= 0 && open_port[d] != pa))
                        $display("FAIL interleave dut%0d: accepted %0d ports, port %0d, open packet port %0d", d, nacc, pa, open_port[d]);
                    else
                        passed++;
                    open_port[d] = src_q[d][pa][0].last ? -1 : pa;
                end
                if (m_tvalid[d] && m_tready[d]) begin
                    checks++;
                    if (exp_q[d].size() == 0) begin
                        $display("FAIL unexpected_beat dut%0d: got tag %08h, required none", d, m_tdata[d][31:0]);
                    end else begin
                        mon_e = exp_q[d].pop_front();
                        if (m_tdata[d] !== mk_data(mon_e.tag) || m_tkeep[d] !== mk_keep(mon_e.tag) ||
                            m_tuser[d] !== mk_user(mon_e.tag) || m_tlast[d] !== mon_e.last)
                            $display("FAIL out_beat dut%0d: got tag %08h last %0b, required tag %08h last %0b",
                                     d, m_tdata[d][31:0], m_tlast[d], mon_e.tag, mon_e.last);
                        else
                            passed++;
                        $display("beat dut%0d tag %08h last %0b cyc %0d", d, m_tdata[d][31:0], m_tlast[d], cyc);
                    end
                    out_cyc[d].push_back(cyc);
                    if (m_tlast[d]) out_pkts[d].push_back(int'(m_tdata[d][23:16]));
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (flush_req) begin
                for (int d = 0; d < 2; d++) begin
                    exp_q[d].delete();
                    open_port[d] = -1;
                    for (int p = 0; p < 2; p++) begin
                        src_q[d][p].delete();
                        acc[d][p] = 1'b0;
                    end
                end
                flush_req = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if (acc[d][p] && src_q[d][p].size() > 0) void'(src_q[d][p].pop_front());
                    if (src_q[d][p].size() > 0) begin
                        s_tdata[d][p]  = mk_data(src_q[d][p][0].tag);
                        s_tkeep[d][p]  = mk_keep(src_q[d][p][0].tag);
                        s_tuser[d][p]  = mk_user(src_q[d][p][0].tag);
                        s_tlast[d][p]  = src_q[d][p][0].last;
                        s_tvalid[d][p] = 1'b1;
                    end else begin
                        s_tvalid[d][p] = 1'b0;
                        s_tlast[d][p]  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (m_tvalid[d] !== 1'b0 || m_tdata[d] !== '0 || m_tkeep[d] !== '0 || m_tuser[d] !== '0 || m_tlast[d] !== 1'b0)
                $display("FAIL reset_m dut%0d: got valid %0b tag %08h, required all zero", d, m_tvalid[d], m_tdata[d][31:0]);
            else passed++;
            checks++;
            if (s_tready[d][0] !== 1'b0 || s_tready[d][1] !== 1'b0 || busy[d] !== 1'b0 || grant[d] !== 1'b0)
                $display("FAIL reset_ctrl dut%0d: got ready %0b%0b busy %0b grant %0b, required 0", d,
                         s_tready[d][1], s_tready[d][0], busy[d], grant[d]);
            else passed++;
            checks++;
            if (cnt0[d] !== 16'd0 || cnt1[d] !== 16'd0)
                $display("FAIL reset_cnt dut%0d: got %04h/%04h, required 0000/0000", d, cnt0[d], cnt1[d]);
            else passed++;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0) $display("FAIL idle_busy dut%0d: got %0b, required 0", d, busy[d]);
            else passed++;
        end
    endtask

    task automatic check_counts(input string name);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cnt0[d] !== exp_cnt[d][0] || cnt1[d] !== exp_cnt[d][1])
                $display("FAIL %s_cnt dut%0d: got %04h/%04h, required %04h/%04h", name, d,
                         cnt0[d], cnt1[d], exp_cnt[d][0], exp_cnt[d][1]);
            else passed++;
            checks++;
            if (exp_q[d].size() != 0)
                $display("FAIL %s_lost dut%0d: got %0d beats never output, required 0", name, d, exp_q[d].size());
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_order[4] = '{0, 1, 0, 1};
        @(negedge clk);
        clear_logs();
        queue_pkt(0, 0, 2, 1);
        queue_pkt(0, 1, 2, 2);
        queue_pkt(0, 0, 2, 3);
        queue_pkt(0, 1, 2, 4);
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL rr_timeout: got busy, required drained");
        else passed++;
        checks++;
        if (out_pkts[0].size() != 4) begin
            $display("FAIL rr_pkts: got %0d packets, required 4", out_pkts[0].size());
        end else begin
            passed++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_pkts[0][i] != exp_order[i])
                    $display("FAIL rr_order[%0d]: got port %0d, required %0d", i, out_pkts[0][i], exp_order[i]);
                else passed++;
            end
        end
        checks++;
        if (out_cyc[0].size() != 8 || out_cyc[0][7] - out_cyc[0][0] != 10)
            $display("FAIL rr_span: got %0d beats, span %0d, required 8 beats, span 10", out_cyc[0].size(),
                     (out_cyc[0].size() > 0) ? out_cyc[0][out_cyc[0].size()-1] - out_cyc[0][0] : -1);
        else passed++;
        check_counts("rr");
    endtask

    task automatic test_priority();
        bit ok;
        bit found;
        int exp_order[4] = '{1, 1, 0, 1};
        @(negedge clk);
        clear_logs();
        queue_pkt(1, 1, 2, 10);
        queue_pkt(1, 1, 2, 11);
        queue_pkt(1, 0, 4, 12);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (busy[1] && grant[1] == 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL prio_p0_grant: got no port 0 grant, required one");
        else passed++;
        queue_pkt(1, 1, 2, 13);
        @(negedge clk);
        checks++;
        if (s_tready[1][1] !== 1'b0 || grant[1] !== 1'b0 || busy[1] !== 1'b1)
            $display("FAIL prio_hold: got ready1 %0b grant %0b busy %0b, required 0 0 1", s_tready[1][1], grant[1], busy[1]);
        else passed++;
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL prio_timeout: got busy, required drained");
        else passed++;
        checks++;
        if (out_pkts[1].size() != 4) begin
            $display("FAIL prio_pkts: got %0d packets, required 4", out_pkts[1].size());
        end else begin
            passed++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_pkts[1][i] != exp_order[i])
                    $display("FAIL prio_order[%0d]: got port %0d, required %0d", i, out_pkts[1][i], exp_order[i]);
                else passed++;
            end
        end
        check_counts("prio");
    endtask

    task automatic test_single();
        bit ok;
        @(negedge clk);
        clear_logs();
        for (int d = 0; d < 2; d++) queue_pkt(d, 0, 3, 20);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || s_tready[d][0] !== 1'b0)
                $display("FAIL single_idle dut%0d: got busy %0b ready %0b, required 0 0", d, busy[d], s_tready[d][0]);
            else passed++;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (grant[d] !== 1'b0 || busy[d] !== 1'b1 || s_tready[d][0] !== 1'b1)
                $display("FAIL single_grant dut%0d: got grant %0b busy %0b ready %0b, required 0 1 1", d,
                         grant[d], busy[d], s_tready[d][0]);
            else passed++;
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (m_tvalid[d] !== 1'b1 || m_tdata[d][31:0] !== mk_tag(d, 0, 20, b) || m_tlast[d] !== (b == 2))
                    $display("FAIL single_beat%0d dut%0d: got valid %0b tag %08h last %0b, required 1 %08h %0b", b, d,
                             m_tvalid[d], m_tdata[d][31:0], m_tlast[d], mk_tag(d, 0, 20, b), (b == 2));
                else passed++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cnt0[d] !== exp_cnt[d][0] || busy[d] !== 1'b0)
                $display("FAIL single_done dut%0d: got cnt0 %04h busy %0b, required %04h 0", d, cnt0[d], busy[d], exp_cnt[d][0]);
            else passed++;
        end
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL single_timeout: got busy, required drained");
        else passed++;
        check_counts("single");
    endtask

    task automatic test_backpressure();
        bit ok;
        @(negedge clk);
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            m_tready[d] = 1'b0;
            queue_pkt(d, 0, 4, 30);
        end
        repeat (8) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (s_tready[d][0] !== 1'b0 || exp_q[d].size() != 2 || src_q[d][0].size() != 2)
                $display("FAIL bp_stall dut%0d: got ready %0b accepted %0d, required 0 and 2", d, s_tready[d][0], exp_q[d].size());
            else passed++;
            checks++;
            if (m_tvalid[d] !== 1'b1 || m_tdata[d][31:0] !== mk_tag(d, 0, 30, 0))
                $display("FAIL bp_head dut%0d: got valid %0b tag %08h, required 1 %08h", d, m_tvalid[d],
                         m_tdata[d][31:0], mk_tag(d, 0, 30, 0));
            else passed++;
        end
        for (int d = 0; d < 2; d++) m_tready[d] = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL bp_timeout: got busy, required drained");
        else passed++;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (out_cyc[d].size() != 4)
                $display("FAIL bp_beats dut%0d: got %0d beats, required 4", d, out_cyc[d].size());
            else passed++;
        end
        check_counts("bp");
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk);
        force u_dut1.cnt1_reg = 16'hFFFF;
        @(negedge clk);
        release u_dut1.cnt1_reg;
        @(negedge clk);
        checks++;
        if (cnt1[1] !== 16'hFFFF) $display("FAIL wrap_preload: got %04h, required ffff", cnt1[1]);
        else passed++;
        exp_cnt[1][1] = 16'hFFFF;
        queue_pkt(1, 1, 1, 40);
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL wrap_timeout: got busy, required drained");
        else passed++;
        checks++;
        if (cnt1[1] !== 16'h0000) $display("FAIL wrap_cnt1: got %04h, required 0000", cnt1[1]);
        else passed++;
        check_counts("wrap");
    endtask

    task automatic test_reset_midpkt();
        bit ok;
        @(negedge clk);
        clear_logs();
        for (int d = 0; d < 2; d++) queue_pkt(d, 0, 4, 50);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (m_tvalid[d] !== 1'b0 || m_tdata[d] !== '0 || busy[d] !== 1'b0 || grant[d] !== 1'b0 ||
                s_tready[d][0] !== 1'b0 || cnt0[d] !== 16'd0 || cnt1[d] !== 16'd0)
                $display("FAIL midrst dut%0d: got valid %0b busy %0b grant %0b cnt %04h/%04h, required all zero", d,
                         m_tvalid[d], busy[d], grant[d], cnt0[d], cnt1[d]);
            else passed++;
            exp_cnt[d][0] = 16'd0;
            exp_cnt[d][1] = 16'd0;
        end
        rst = 1'b1;
        @(negedge clk);
        clear_logs();
        queue_pkt(0, 1, 2, 51);
        queue_pkt(0, 0, 2, 52);
        queue_pkt(1, 0, 3, 53);
        wait_drain(ok);
        checks++;
        if (!ok) $display("FAIL midrst_timeout: got busy, required drained");
        else passed++;
        checks++;
        if (out_pkts[0].size() != 2 || out_pkts[0][0] != 0 || out_pkts[0][1] != 1)
            $display("FAIL midrst_order: got %0d packets first port %0d, required 2 first port 0",
                     out_pkts[0].size(), (out_pkts[0].size() > 0) ? out_pkts[0][0] : -1);
        else passed++;
        checks++;
        if (out_pkts[1].size() != 1) $display("FAIL midrst_dut1: got %0d packets, required 1", out_pkts[1].size());
        else passed++;
        check_counts("midrst");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        passed    = 0;
        cyc       = 0;
        flush_req = 1'b0;
        rst       = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_tready[d]   = 1'b1;
            exp_cnt[d][0] = 16'd0;
            exp_cnt[d][1] = 16'd0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        test_round_robin();
        test_priority();
        test_single();
        test_backpressure();
        test_wrap();
        test_reset_midpkt();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
